// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: issue-side signals between operand_fetch (master) and the hazard unit (slave)
interface hazard_scoreboard_unit_if #(
  parameter int NUM_REGS   = 16,
  parameter int PIPE_DEPTH = 3,
  parameter int NUM_SRC    = 2
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int SW = $clog2(PIPE_DEPTH + 1);
  logic                  id_valid;
  logic [NUM_SRC*RW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]    id_src_used;
  logic                  id_reads_flag;
  logic [RW-1:0]         id_dst_addr;
  logic                  id_dst_we;
  logic                  id_is_load;
  logic                  branch_taken;
  logic                  issue_fire;
  logic                  data_stall;
  logic                  control_stall;
  logic [NUM_SRC*SW-1:0] fwd_sel;
  logic [15:0]           stall_count;
  modport master (
    output id_valid, id_src_addr, id_src_used, id_reads_flag, id_dst_addr, id_dst_we, id_is_load, branch_taken,
    input  issue_fire, data_stall, control_stall, fwd_sel, stall_count
  );
  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_reads_flag, id_dst_addr, id_dst_we, id_is_load, branch_taken,
    output issue_fire, data_stall, control_stall, fwd_sel, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: RAW stall / branch flush / forwarding select over a tag shift-pipe.
// Define HAZARD_FORWARD_EN to enable operand forwarding; otherwise every match stalls.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS     = 16,
  parameter int FLAG_REG     = 15,
  parameter int PIPE_DEPTH   = 3,
  parameter int NUM_SRC      = 2,
  parameter int BRANCH_STAGE = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int SW = $clog2(PIPE_DEPTH + 1);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [PIPE_DEPTH-1:0] tag_v, tag_l;
  logic [RW-1:0]         tag_a [PIPE_DEPTH];
  logic [NUM_SRC-1:0]    src_stall;
  logic [NUM_SRC*SW-1:0] fwd;
  logic                  flag_hit, hazard, ctrl, fire;
  logic [15:0]           stall_cnt;
  // Stages are scanned oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    src_stall = '0;
    fwd = '0;
    flag_hit = 1'b0;
    for (int s = 0; s < PIPE_DEPTH; s++)
      flag_hit = flag_hit | (tag_v[s] && tag_a[s] == RW'(FLAG_REG));
    for (int i = 0; i < NUM_SRC; i++)
      for (int s = PIPE_DEPTH - 1; s >= 0; s--)
        if (hz.id_src_used[i] && tag_v[s] && tag_a[s] == hz.id_src_addr[i*RW +: RW]) begin
          src_stall[i] = !FWD || (tag_l[s] && s != PIPE_DEPTH - 1);
          fwd[i*SW +: SW] = src_stall[i] ? '0 : SW'(s + 1);
        end
  end
  assign hazard = (|src_stall) | (hz.id_reads_flag & flag_hit);
  assign ctrl = (state == FLUSH) | hz.branch_taken;
  assign fire = hz.id_valid & ~hazard & ~ctrl;
  assign hz.control_stall = ctrl;
  assign hz.data_stall = hz.id_valid & hazard & ~ctrl;
  assign hz.issue_fire = fire;
  assign hz.fwd_sel = fwd;
  assign hz.stall_count = stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tag_v <= '0;
      tag_l <= '0;
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 16'((hz.data_stall | ctrl) && stall_cnt != 16'hFFFF);
      tag_v[0] <= fire & hz.id_dst_we;
      tag_l[0] <= fire & hz.id_is_load;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        tag_v[s] <= tag_v[s-1] & ~(hz.branch_taken && s < BRANCH_STAGE);
        tag_l[s] <= tag_l[s-1];
      end
      if (hz.branch_taken) begin
        state <= FLUSH;
        cnt <= CW'(FLUSH_CYCLES);
      end else if (state == FLUSH) begin
        cnt <= cnt - 1'b1;
        state <= (cnt == CW'(1)) ? IDLE : FLUSH;
      end
    end
  end
  always_ff @(posedge clk) begin
    tag_a[0] <= hz.id_dst_addr;
    for (int s = 1; s < PIPE_DEPTH; s++)
      tag_a[s] <= tag_a[s-1];
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed hazard scenarios plus random traffic, scored against an in-flight list model.
module tb_hazard_scoreboard_unit;
  localparam int NR = 16, FR = 15, PD = 3, NS = 2, BS = 1, FC = 2;
  localparam int RW = $clog2(NR);
  localparam int SW = $clog2(PD + 1);
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    bit chk;
    bit ds, cs, fire;
    logic [NS*SW-1:0] fwd;
    int sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.NUM_REGS(NR), .PIPE_DEPTH(PD), .NUM_SRC(NS)) hz();
  hazard_scoreboard_unit #(
    .NUM_REGS(NR), .FLAG_REG(FR), .PIPE_DEPTH(PD), .NUM_SRC(NS), .BRANCH_STAGE(BS), .FLUSH_CYCLES(FC)
  ) dut (.clk(clk), .rst(rst), .hz(hz.slave));

  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t me;
  bit chk_en = 0, last_fire = 0;
  bit in_v, in_rf, in_we, in_ld, in_br;
  logic [NS*RW-1:0] in_sa;
  logic [NS-1:0] in_su;
  logic [RW-1:0] in_da;
  // In-flight instructions by age (0 = just issued), flush cycles still owed, stalled-cycle total.
  bit mv[PD];
  int mr[PD];
  bit ml[PD];
  int m_flush = 0, m_sc = 0;

  function automatic exp_t model_eval();
    exp_t e;
    bit haz = 0;
    e.chk = chk_en;
    e.fwd = '0;
    e.cs = in_br || m_flush > 0;
    for (int i = 0; i < NS; i++)
      if (in_su[i]) begin
        int src = int'(in_sa[i*RW +: RW]);
        for (int a = 0; a < PD; a++)
          if (mv[a] && mr[a] == src) begin
            if (FWD && !(ml[a] && a != PD - 1)) e.fwd[i*SW +: SW] = SW'(a + 1);
            else haz = 1;
            break;
          end
      end
    if (in_rf)
      for (int a = 0; a < PD; a++)
        if (mv[a] && mr[a] == FR) haz = 1;
    e.ds = in_v && haz && !e.cs;
    e.fire = in_v && !haz && !e.cs;
    e.sc = m_sc;
    return e;
  endfunction

  task automatic model_update(input exp_t e);
    if (rst) begin
      for (int a = 0; a < PD; a++) mv[a] = 0;
      m_flush = 0;
      m_sc = 0;
    end else begin
      if ((e.ds || e.cs) && m_sc < 65535) m_sc++;
      for (int a = PD - 1; a > 0; a--) begin
        mv[a] = mv[a-1];
        mr[a] = mr[a-1];
        ml[a] = ml[a-1];
      end
      mv[0] = e.fire && in_we;
      mr[0] = int'(in_da);
      ml[0] = in_ld;
      if (in_br)
        for (int a = 0; a < BS; a++) mv[a] = 0;
      m_flush = in_br ? FC : (m_flush > 0 ? m_flush - 1 : 0);
    end
  endtask

  task automatic step();
    exp_t e;
    hz.id_valid = in_v;
    hz.id_src_addr = in_sa;
    hz.id_src_used = in_su;
    hz.id_reads_flag = in_rf;
    hz.id_dst_addr = in_da;
    hz.id_dst_we = in_we;
    hz.id_is_load = in_ld;
    hz.branch_taken = in_br;
    e = model_eval();
    last_fire = e.fire;
    q.push_back(e);
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic set_instr(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                           input int dst, input bit we, input bit ld, input bit br);
    in_v = v;
    in_sa = {RW'(s1), RW'(s0)};
    in_su = {u1, u0};
    in_rf = 0;
    in_da = RW'(dst);
    in_we = we;
    in_ld = ld;
    in_br = br;
  endtask

  task automatic hold_until_fire();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_fire && n < 10);
  endtask

  task automatic idle(input int n);
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  function automatic logic [RW-1:0] pick();
    int r = $urandom_range(0, 4);
    return (r == 4) ? RW'(FR) : RW'(r);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      me = q.pop_front();
      if (me.chk) begin
        check("data_stall", int'(hz.data_stall), int'(me.ds));
        check("control_stall", int'(hz.control_stall), int'(me.cs));
        check("issue_fire", int'(hz.issue_fire), int'(me.fire));
        check("stall_count", int'(hz.stall_count), me.sc);
        if (me.fire) check("fwd_sel", int'(hz.fwd_sel), int'(me.fwd));
      end
    end

  initial begin
    rst = 1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    chk_en = 1;
    step();
    rst = 0;
    idle(2);
    // ADD r3 followed by a reader of r3
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0); step();
    set_instr(1, 3, 1, 0, 0, 6, 1, 0, 0); hold_until_fire();
    idle(3);
    // LOAD r5 followed by a reader of r5 on src1
    set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_instr(1, 2, 1, 5, 1, 7, 1, 0, 0); hold_until_fire();
    idle(3);
    // taken branch alone, then with a simultaneous data hazard
    set_instr(1, 0, 0, 0, 0, 8, 1, 0, 0); step();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle(4);
    set_instr(1, 0, 0, 0, 0, 2, 1, 0, 0); step();
    set_instr(1, 2, 1, 0, 0, 9, 1, 0, 1); step();
    set_instr(1, 2, 1, 0, 0, 9, 1, 0, 0); hold_until_fire();
    idle(3);
    // flag read behind a flag writer
    set_instr(1, 0, 0, 0, 0, FR, 1, 0, 0); step();
    set_instr(1, 0, 0, 0, 0, 1, 0, 0, 0); in_rf = 1; hold_until_fire();
    idle(3);
    // reset while a reader is stalled on valid tags
    set_instr(1, 0, 0, 0, 0, 4, 1, 0, 0); step();
    set_instr(1, 4, 1, 0, 0, 10, 1, 0, 0); step();
    rst = 1; step();
    rst = 0; step();
    idle(2);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_v = ($urandom_range(0, 3) != 0);
      in_sa = {pick(), pick()};
      in_su = NS'($urandom);
      in_rf = ($urandom_range(0, 5) == 0);
      in_da = pick();
      in_we = ($urandom_range(0, 4) != 0);
      in_ld = ($urandom_range(0, 2) == 0);
      in_br = ($urandom_range(0, 11) == 0);
      step();
    end
    rst = 0;
    idle(2);
    for (int n = 0; n < 5 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
